// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - sequential accumulator for a radix-2 Booth partial-product bundle
// Captures pp0..pp15 plus sign-extend vector S, sums PPS_PER_CYCLE terms per clock into a 32-bit product.
module booth_pp_accumulator #(
   parameter int PPS_PER_CYCLE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] pp0,
   input  logic [15:0] pp1,
   input  logic [15:0] pp2,
   input  logic [15:0] pp3,
   input  logic [15:0] pp4,
   input  logic [15:0] pp5,
   input  logic [15:0] pp6,
   input  logic [15:0] pp7,
   input  logic [15:0] pp8,
   input  logic [15:0] pp9,
   input  logic [15:0] pp10,
   input  logic [15:0] pp11,
   input  logic [15:0] pp12,
   input  logic [15:0] pp13,
   input  logic [15:0] pp14,
   input  logic [15:0] pp15,
   input  logic [15:0] S,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product,
   output logic        sign_err
);

   localparam int N_CYC = 16 / PPS_PER_CYCLE;

   generate
      if (PPS_PER_CYCLE != 1 && PPS_PER_CYCLE != 2 && PPS_PER_CYCLE != 4 &&
          PPS_PER_CYCLE != 8 && PPS_PER_CYCLE != 16) begin : g_bad_param
         $error("booth_pp_accumulator: PPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t      state;
   logic [15:0] pp_in [16];
   logic [15:0] pp_q  [16];
   logic [15:0] s_q;
   logic [32:0] acc;
   logic [3:0]  cnt;
   logic [32:0] step_sum;
   logic [3:0]  idx;
   logic        err_in;

   assign pp_in[0]  = pp0;   assign pp_in[1]  = pp1;   assign pp_in[2]  = pp2;   assign pp_in[3]  = pp3;
   assign pp_in[4]  = pp4;   assign pp_in[5]  = pp5;   assign pp_in[6]  = pp6;   assign pp_in[7]  = pp7;
   assign pp_in[8]  = pp8;   assign pp_in[9]  = pp9;   assign pp_in[10] = pp10;  assign pp_in[11] = pp11;
   assign pp_in[12] = pp12;  assign pp_in[13] = pp13;  assign pp_in[14] = pp14;  assign pp_in[15] = pp15;

   assign product = acc[31:0];

   always_comb begin
      err_in = 1'b0;
      for (int i = 0; i < 16; i++) begin
         err_in = err_in | (S[i] ^ pp_in[i][15]);
      end
   end

   // S supplies bit 16 of each term, so a 0x8000 PP with S=1 stays negative.
   always_comb begin
      step_sum = '0;
      idx      = '0;
      for (int j = 0; j < PPS_PER_CYCLE; j++) begin
         idx      = 4'(int'(cnt) * PPS_PER_CYCLE + j);
         step_sum = step_sum + ({{16{s_q[idx]}}, s_q[idx], pp_q[idx]} << idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sign_err  <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         s_q       <= '0;
         for (int i = 0; i < 16; i++) pp_q[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < 16; i++) pp_q[i] <= pp_in[i];
                  s_q      <= S;
                  acc      <= '0;
                  cnt      <= '0;
                  sign_err <= err_in;
                  in_ready <= 1'b0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc + step_sum;
               cnt <= cnt + 4'd1;
               if (cnt == 4'(N_CYC - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
